// File: rtl/sa_step_counter.sv
// Step sequencer for the systolic-array MUX-select decoder: cnt 0..LAST_STEP per tile.
// Define SA_STEP_ERR_EN to add the sticky start_err output for starts seen while busy.
module sa_step_counter #(
    parameter int CNT_W     = 4,
    parameter int LAST_STEP = 8,
    parameter int TILE_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              stall,
    output logic [CNT_W-1:0]  cnt,
    output logic [TILE_W-1:0] tile_idx,
    output logic              step_valid,
    output logic              busy,
    output logic              done
`ifdef SA_STEP_ERR_EN
    ,
    output logic              start_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_STEP);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tile_d  = tile_q;
        tiles_d = tiles_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                tile_d = '0;
                if (start) begin
                    tiles_d = num_tiles;
                    state_d = (num_tiles == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Stall freezes everything, including the final step of a tile.
                if (!stall) begin
                    if (cnt_q < LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (tile_q < tiles_q - TILE_W'(1)) begin
                            tile_d = tile_q + TILE_W'(1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tile_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tile_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tile_q  <= '0;
            tiles_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tile_q  <= tile_d;
            tiles_q <= tiles_d;
        end
    end

`ifdef SA_STEP_ERR_EN
    logic err_q, err_d;

    assign err_d = err_q | (start && (state_q != S_IDLE));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign start_err = err_q;
`endif

    assign cnt        = cnt_q;
    assign tile_idx   = tile_q;
    assign step_valid = (state_q == S_RUN) && !stall;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule
